// File: rtl/alu_pkg.sv
// alu_pkg -- constants shared by the ALU and its iterative multiply/divide
// unit: the opcode values for MUL and DIV, the final iteration index of the
// 32-step loop, and the FSM state encoding.
package alu_pkg;

  localparam logic [4:0] OP_MUL    = 5'd2;
  localparam logic [4:0] OP_DIV    = 5'd3;

  // RUN performs one iteration per cycle; this is the index of the last one.
  localparam logic [4:0] LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv -- iterative signed 32x32 multiply (radix-2 Booth) and signed
// 32/32 divide (restoring, on magnitudes) sharing one 64-bit accumulator.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        operation request, sampled only while idle
//   OpCode[4:0]  2 = MUL, 3 = DIV, anything else completes at once with C = 0
//   A[31:0]      multiplicand / dividend, captured when start is accepted
//   B[31:0]      multiplier / divisor, captured when start is accepted
//   busy         high whenever the FSM is not idle
//   done         one-cycle pulse when C is valid
//   C[63:0]      MUL: {hi, lo}; DIV: {remainder, quotient}; held until next done
//   div_by_zero  set with done for DIV by zero, held with C
//
// Iterative ops take 32 RUN cycles plus one FIX cycle, so done is seen 34
// cycles after start is sampled; DIV by zero and unknown opcodes skip
// straight to DONE and finish one cycle after start.
module alu_muldiv
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  OpCode,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [63:0] C,
  output logic        div_by_zero
);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic        q1_q, q1_d;
  logic [63:0] c_q, c_d;
  logic        dbz_q, dbz_d;

  logic [31:0] quo_fix, rem_fix;

  // Two's-complement magnitude; 32'h80000000 maps to itself, which is the
  // correct unsigned magnitude 2^31.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // One Booth step on {hi, lo, q-1}. The add/subtract is done at 33 bits so
  // that hi - (-2^31) cannot overflow; the arithmetic shift then brings the
  // high half back into 32 bits.
  function automatic logic [64:0] booth_step(input logic [63:0] acc,
                                             input logic        q1,
                                             input logic [31:0] mcand);
    logic [32:0] hi;
    hi = {acc[63], acc[63:32]};
    case ({acc[0], q1})
      2'b01:   hi = hi + {mcand[31], mcand};
      2'b10:   hi = hi - {mcand[31], mcand};
      default: hi = hi;
    endcase
    return {hi, acc[31:1], acc[0]};
  endfunction

  // One restoring step on {rem, quo}: shift left, trial-subtract the divisor
  // from the partial remainder, keep the difference when it is non-negative.
  function automatic logic [63:0] restore_step(input logic [63:0] acc,
                                               input logic [31:0] dvsr);
    logic [32:0] rem_sh;
    logic [32:0] trial;
    rem_sh = acc[63:31];
    trial  = rem_sh - {1'b0, dvsr};
    if (!trial[32]) begin
      return {trial[31:0], acc[30:0], 1'b1};
    end
    return {rem_sh[31:0], acc[30:0], 1'b0};
  endfunction

  // Sign correction for DIV: quotient negative when operand signs differ,
  // remainder follows the dividend. -2^31 / -1 wraps back to 32'h80000000.
  assign quo_fix = cond_neg(acc_q[31:0], a_q[31] ^ b_q[31]);
  assign rem_fix = cond_neg(acc_q[63:32], a_q[31]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      q1_q    <= 1'b0;
      c_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      q1_q    <= q1_d;
      c_q     <= c_d;
      dbz_q   <= dbz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    q1_d    = q1_q;
    c_d     = c_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d   = A;
          b_d   = B;
          op_d  = OpCode;
          cnt_d = '0;
          q1_d  = 1'b0;
          if (OpCode == OP_MUL) begin
            acc_d   = {32'b0, B};
            state_d = ST_RUN;
          end else if (OpCode == OP_DIV && B != 32'd0) begin
            acc_d   = {32'b0, mag32(A)};
            state_d = ST_RUN;
          end else if (OpCode == OP_DIV) begin
            c_d     = {A, 32'hFFFF_FFFF};
            dbz_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            c_d     = '0;
            dbz_d   = 1'b0;
            state_d = ST_DONE;
          end
        end
      end

      ST_RUN: begin
        if (op_q == OP_MUL) begin
          {acc_d, q1_d} = booth_step(acc_q, q1_q, a_q);
        end else begin
          acc_d = restore_step(acc_q, mag32(b_q));
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        c_d     = (op_q == OP_MUL) ? acc_q : {rem_fix, quo_fix};
        dbz_d   = 1'b0;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy        = (state_q != ST_IDLE);
    done        = (state_q == ST_DONE);
    C           = c_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv -- self-checking bench for alu_muldiv. Directed cases use
// hand-derived constants; random cases use a plain-arithmetic reference.
module tb_alu_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  OpCode;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [63:0] C;
  logic        div_by_zero;

  int total;
  int bad;
  logic [63:0] hold_c;

  alu_muldiv dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .OpCode      (OpCode),
    .A           (A),
    .B           (B),
    .busy        (busy),
    .done        (done),
    .C           (C),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: signed arithmetic on 64-bit integers.
  function automatic void ref_model(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [63:0] c,
                                    output logic dbz, output int lat);
    longint la, lb, q, r;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    c = '0; dbz = 1'b0; lat = 1;
    if (op == 5'd2) begin
      c = la * lb;
      lat = 34;
    end else if (op == 5'd3 && b == 32'd0) begin
      c = {a, 32'hFFFF_FFFF};
      dbz = 1'b1;
    end else if (op == 5'd3) begin
      q = la / lb;
      r = la % lb;
      c = {r[31:0], q[31:0]};
      lat = 34;
    end
  endfunction

  // Issues one op and observes it: latency in cycles from the start-sampling
  // edge to done, C and flag at done, C mid-operation, busy just after
  // start, and whether done/busy were low the cycle after done.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] c, output logic dbz,
                        output logic [63:0] c_mid, output logic busy1, output logic post_ok);
    int k;
    c_mid = 'x;
    @(negedge clk);
    start = 1'b1; OpCode = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; OpCode = 5'($urandom); A = $urandom; B = $urandom;
    k = 1;
    busy1 = busy;
    while (done !== 1'b1 && k < 40) begin
      if (k == 17) c_mid = C;
      @(negedge clk);
      k++;
    end
    lat = k;
    c = C;
    dbz = div_by_zero;
    @(negedge clk);
    post_ok = (done === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (C !== 64'd0) begin bad++; $display("FAIL reset_C got=%h want=0", C); end
    total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL reset_dbz got=%b want=0", div_by_zero); end
    // reset and start in the same cycle: reset wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1; OpCode = 5'd2; A = 32'd3; B = 32'd4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_prio_busy got=%b want=0", busy); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_prio_idle busy=%b done=%b want=0,0", busy, done); end
    hold_c = 64'd0;
  endtask

  task automatic test_mul();
    int lat; logic [63:0] c, cm; logic dbz, b1, po;
    run_op(5'd2, 32'd7, 32'hFFFF_FFFD, lat, c, dbz, cm, b1, po);
    total++; if (b1 !== 1'b1) begin bad++; $display("FAIL mul_busy got=%b want=1", b1); end
    total++; if (lat != 34) begin bad++; $display("FAIL mul_latency got=%0d want=34", lat); end
    total++; if (c !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mul_7x-3 got=%h want=ffffffffffffffeb", c); end
    total++; if (cm !== hold_c) begin bad++; $display("FAIL mul_C_hold got=%h want=%h", cm, hold_c); end
    total++; if (po !== 1'b1) begin bad++; $display("FAIL mul_done_once got=0 want=1"); end
    hold_c = 64'hFFFF_FFFF_FFFF_FFEB;
    run_op(5'd2, 32'h8000_0000, 32'h8000_0000, lat, c, dbz, cm, b1, po);
    total++; if (c !== 64'h4000_0000_0000_0000) begin bad++; $display("FAIL mul_min2 got=%h want=4000000000000000", c); end
    total++; if (cm !== hold_c) begin bad++; $display("FAIL mul_min2_hold got=%h want=%h", cm, hold_c); end
    total++; if (po !== 1'b1) begin bad++; $display("FAIL mul_min2_done_once got=0 want=1"); end
    hold_c = 64'h4000_0000_0000_0000;
  endtask

  task automatic test_div();
    int lat; logic [63:0] c, cm; logic dbz, b1, po;
    run_op(5'd3, 32'd100, 32'd7, lat, c, dbz, cm, b1, po);
    total++; if (lat != 34) begin bad++; $display("FAIL div_latency got=%0d want=34", lat); end
    total++; if (c !== 64'h0000_0002_0000_000E) begin bad++; $display("FAIL div_100/7 got=%h want=000000020000000e", c); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL div_100/7_dbz got=%b want=0", dbz); end
    run_op(5'd3, 32'hFFFF_FFF9, 32'd2, lat, c, dbz, cm, b1, po);
    total++; if (c !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_-7/2 got=%h want=fffffffffffffffd", c); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL div_-7/2_dbz got=%b want=0", dbz); end
    run_op(5'd3, 32'h8000_0000, 32'hFFFF_FFFF, lat, c, dbz, cm, b1, po);
    total++; if (c !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL div_min/-1 got=%h want=0000000080000000", c); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL div_min/-1_dbz got=%b want=0", dbz); end
    total++; if (po !== 1'b1) begin bad++; $display("FAIL div_done_once got=0 want=1"); end
    hold_c = 64'h0000_0000_8000_0000;
  endtask

  task automatic test_div_by_zero();
    int lat; logic [63:0] c, cm; logic dbz, b1, po;
    run_op(5'd3, 32'd5, 32'd0, lat, c, dbz, cm, b1, po);
    total++; if (lat != 1) begin bad++; $display("FAIL dbz_latency got=%0d want=1", lat); end
    total++; if (c !== 64'h0000_0005_FFFF_FFFF) begin bad++; $display("FAIL dbz_C got=%h want=00000005ffffffff", c); end
    total++; if (dbz !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b want=1", dbz); end
    total++; if (po !== 1'b1) begin bad++; $display("FAIL dbz_done_once got=0 want=1"); end
    total++; if (div_by_zero !== 1'b1) begin bad++; $display("FAIL dbz_flag_held got=%b want=1", div_by_zero); end
    run_op(5'd3, 32'd9, 32'd3, lat, c, dbz, cm, b1, po);
    total++; if (cm !== 64'h0000_0005_FFFF_FFFF) begin bad++; $display("FAIL dbz_C_hold got=%h want=00000005ffffffff", cm); end
    total++; if (c !== 64'h0000_0000_0000_0003) begin bad++; $display("FAIL div_9/3 got=%h want=0000000000000003", c); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL div_9/3_dbz got=%b want=0", dbz); end
    hold_c = 64'h3;
  endtask

  task automatic test_bad_opcode();
    int lat; logic [63:0] c, cm; logic dbz, b1, po;
    run_op(5'd3, 32'd1, 32'd0, lat, c, dbz, cm, b1, po);
    run_op(5'd9, 32'd123, 32'd456, lat, c, dbz, cm, b1, po);
    total++; if (lat != 1) begin bad++; $display("FAIL badop_latency got=%0d want=1", lat); end
    total++; if (c !== 64'd0) begin bad++; $display("FAIL badop_C got=%h want=0", c); end
    total++; if (dbz !== 1'b0) begin bad++; $display("FAIL badop_dbz got=%b want=0", dbz); end
    total++; if (po !== 1'b1) begin bad++; $display("FAIL badop_done_once got=0 want=1"); end
    hold_c = 64'd0;
  endtask

  // start re-asserted mid-operation must not disturb the running op
  task automatic test_start_ignored();
    int k; logic [63:0] c;
    @(negedge clk);
    start = 1'b1; OpCode = 5'd2; A = 32'd7; B = 32'hFFFF_FFFD;
    @(negedge clk);
    start = 1'b0; A = 32'd0; B = 32'd0;
    k = 1;
    while (done !== 1'b1 && k < 40) begin
      if (k == 5) begin start = 1'b1; OpCode = 5'd3; A = 32'd100; B = 32'd7; end
      else start = 1'b0;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    c = C;
    total++; if (k != 34) begin bad++; $display("FAIL ignore_latency got=%0d want=34", k); end
    total++; if (c !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL ignore_C got=%h want=ffffffffffffffeb", c); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ignore_done_once done=%b busy=%b want=0,0", done, busy); end
    hold_c = 64'hFFFF_FFFF_FFFF_FFEB;
  endtask

  task automatic test_abort();
    int lat; logic [63:0] c, cm; logic dbz, b1, po;
    int seen_done;
    seen_done = 0;
    @(negedge clk);
    start = 1'b1; OpCode = 5'd2; A = 32'd3; B = 32'd4;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = (k == 5);
      if (k == 5) begin OpCode = 5'd3; A = 32'd100; B = 32'd7; end
      rst = (k == 10);
      if (done === 1'b1) seen_done++;
      if (k == 11) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (C !== 64'd0) begin bad++; $display("FAIL abort_C got=%h want=0", C); end
        total++; if (div_by_zero !== 1'b0) begin bad++; $display("FAIL abort_dbz got=%b want=0", div_by_zero); end
      end
    end
    total++; if (seen_done != 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", seen_done); end
    hold_c = 64'd0;
    run_op(5'd2, 32'd3, 32'd4, lat, c, dbz, cm, b1, po);
    total++; if (lat != 34) begin bad++; $display("FAIL after_abort_latency got=%0d want=34", lat); end
    total++; if (c !== 64'h0000_0000_0000_000C) begin bad++; $display("FAIL after_abort_C got=%h want=000000000000000c", c); end
    hold_c = 64'hC;
  endtask

  task automatic test_random();
    int lat, elat, sel; logic [63:0] c, cm, ec; logic dbz, edbz, b1, po;
    logic [4:0] op; logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 9);
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) b = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
      if (sel < 4) op = 5'd2;
      else if (sel < 8) op = 5'd3;
      else if (sel == 8) begin op = 5'd3; b = 32'd0; end
      else begin
        op = 5'($urandom);
        if (op == 5'd2 || op == 5'd3) op = 5'd31;
      end
      ref_model(op, a, b, ec, edbz, elat);
      run_op(op, a, b, lat, c, dbz, cm, b1, po);
      total++; if (lat != elat) begin bad++; $display("FAIL rand%0d_latency op=%0d got=%0d want=%0d", n, op, lat, elat); end
      total++; if (c !== ec) begin bad++; $display("FAIL rand%0d_C op=%0d a=%h b=%h got=%h want=%h", n, op, a, b, c, ec); end
      total++; if (dbz !== edbz) begin bad++; $display("FAIL rand%0d_dbz got=%b want=%b", n, dbz, edbz); end
      total++; if (po !== 1'b1) begin bad++; $display("FAIL rand%0d_done_once got=0 want=1", n); end
      if (elat == 34) begin
        total++; if (cm !== hold_c) begin bad++; $display("FAIL rand%0d_C_hold got=%h want=%h", n, cm, hold_c); end
      end
      hold_c = ec;
    end
  endtask

  initial begin
    total = 0; bad = 0; hold_c = 64'd0;
    rst = 1'b1; start = 1'b0; OpCode = 5'd0; A = 32'd0; B = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_bad_opcode();
    test_start_ignored();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 The port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-002 The port rst, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-003 The port start, input, 1 bit, SHALL request one operation and is sampled only in IDLE.
REQ-004 The port OpCode, input, 5 bits, SHALL select the operation, using the ALU encoding: 5'd2 = MUL, 5'd3 = DIV.
REQ-005 The ports A and B, inputs, 32 bits each, SHALL be the operands, captured on the cycle start is accepted.
REQ-006 The port busy, output, 1 bit, SHALL be high whenever the FSM is not in IDLE.
REQ-007 The port done, output, 1 bit, SHALL pulse high for exactly one cycle when C is valid.
REQ-008 The port C, output, 64 bits, SHALL carry the result and hold it until the next done.
REQ-009 The port div_by_zero, output, 1 bit, SHALL be valid with done and held with C.

Function
REQ-010 The FSM SHALL have the states IDLE, RUN, FIX and DONE.
REQ-011 In IDLE with start=1, the block SHALL latch A, B and OpCode; MUL, or DIV with B≠0, SHALL go to RUN with the iteration counter set to 0.
REQ-012 Start asserted outside IDLE SHALL be ignored; the latched operands SHALL be unaffected.
REQ-013 RUN SHALL last exactly 32 cycles, one iteration per cycle; it SHALL exit to FIX when the counter reaches 31.
REQ-014 FIX SHALL apply sign correction, write C, then go to DONE; DONE SHALL assert done and return to IDLE.
REQ-015 Latency, for start sampled in cycle N, SHALL be: done in cycle N+34 for the iterative path, and in cycle N+1 for the fast path.
REQ-016 MUL SHALL treat operands as 32-bit signed two's complement, use radix-2 Booth, and give a full 64-bit signed product: C = {hi, lo}.
REQ-017 DIV SHALL be signed, use a restoring algorithm on magnitudes, and give C = {remainder, quotient}; quotient is truncated toward zero; remainder takes the sign of A.
REQ-018 DIV with B = 0 SHALL take the fast path: C = {A, 32'hFFFFFFFF}, div_by_zero = 1.
REQ-019 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give quotient 32'h80000000 and remainder 0, with no flag.
REQ-020 Any OpCode other than 2 or 3 SHALL take the fast path with C = 64'b0 and div_by_zero = 0.
REQ-021 div_by_zero SHALL be cleared on every non-div-by-zero completion.
REQ-022 C SHALL change only on the transition into DONE.

Reset
REQ-023 With rst=1 at a clock edge, the block SHALL set the FSM to IDLE, busy=0, done=0, C=64'b0, div_by_zero=0, and the counter and operand registers to 0.
REQ-024 Reset during RUN or FIX SHALL abort the operation with no done pulse.
REQ-025 Reset SHALL take priority over a start asserted in the same cycle.

Structure
REQ-026 The opcode constants (OP_MUL=5'd2, OP_DIV=5'd3) and the FSM state encoding SHALL live in the shared package alu_pkg, also used by ALU.
REQ-027 The block SHALL be a single module with no sub-module; the Booth and restoring datapaths SHALL share one 64-bit accumulator register.

Verification
REQ-028 MUL 7 × -3 (B=32'hFFFFFFFD) -> done in cycle N+34, C=64'hFFFFFFFF_FFFFFFEB.
REQ-029 MUL 32'h80000000 × 32'h80000000 -> C=64'h40000000_00000000; DIV 32'h80000000 / 32'hFFFFFFFF -> C=64'h00000000_80000000.
REQ-030 DIV 100/7 -> C=64'h00000002_0000000E; DIV -7/2 -> C=64'hFFFFFFFF_FFFFFFFD; div_by_zero=0 for both.
REQ-031 DIV 5/0 -> done in cycle N+1, C=64'h00000005_FFFFFFFF, div_by_zero=1; the next DIV 9/3 -> C=64'h00000000_00000003, div_by_zero=0.
REQ-032 Start MUL 3×4, start re-asserted with DIV at cycle N+5, rst at cycle N+10 -> no done pulse, busy=0 and C=0 from N+11; a later MUL 3×4 -> C=64'h0000000C.
REQ-033 OpCode 5'd9 -> done in cycle N+1 with C=64'b0, and done is never high for two consecutive cycles in any test.
